// File: rtl/fuzz_stim_ctrl.sv
// fuzz_stim_ctrl: LCG-driven stimulus sequencer that resets a DUT, streams vectors and folds responses into a signature.
module fuzz_stim_ctrl #(
    parameter int          IN_W       = 136,
    parameter int          OUT_W      = 159,
    parameter int          RST_CYCLES = 2,
    parameter logic [31:0] LCG_MUL    = 32'h41C64E6D,
    parameter logic [31:0] LCG_INC    = 32'h3039
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic [31:0]      seed,
    input  logic [31:0]      cycles,
    output logic             dut_rst_n,
    output logic [IN_W-1:0]  in_flat,
    input  logic [OUT_W-1:0] out_flat,
    output logic             busy,
    output logic             done,
    output logic [31:0]      signature,
    output logic [31:0]      vec_cnt
);
    localparam int IW  = (IN_W + 31) / 32;
    localparam int OWW = (OUT_W + 31) / 32;
    localparam int LB  = IN_W - 32 * (IW - 1);

    typedef enum logic [2:0] {IDLE, RST, SETTLE, RUN, DONE} state_t;

    state_t            state_q, state_d;
    logic [31:0]       lcg_q, lcg_d, cyc_q, cyc_d, sig_q, sig_d, cnt_q, cnt_d, rcnt_q, rcnt_d;
    logic [IN_W-1:0]   vec_q, vec_d;
    logic              dut_rst_n_q;
    logic [31:0]       gen_src, gen_end, fold;
    logic [IN_W-1:0]   gen_vec;

    // One full vector per cycle: IW chained LCG steps, last word truncated.
    always_comb begin
        gen_src = (state_q == IDLE) ? seed : lcg_q;
        gen_end = gen_src;
        gen_vec = '0;
        for (int k = 0; k < IW - 1; k++) begin
            gen_end = gen_end * LCG_MUL + LCG_INC;
            gen_vec[32*k +: 32] = gen_end;
        end
        gen_end = gen_end * LCG_MUL + LCG_INC;
        gen_vec[IN_W-1 -: LB] = gen_end[LB-1:0];
    end

    always_comb begin
        fold = 32'(out_flat[OUT_W-1:32*(OWW-1)]);
        for (int k = 0; k < OWW - 1; k++)
            fold = fold ^ out_flat[32*k +: 32];
    end

    always_comb begin
        state_d = state_q;
        lcg_d   = lcg_q;
        cyc_d   = cyc_q;
        sig_d   = sig_q;
        cnt_d   = cnt_q;
        rcnt_d  = rcnt_q;
        vec_d   = vec_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RST;
                    cyc_d   = cycles;
                    vec_d   = gen_vec;
                    lcg_d   = gen_end;
                    sig_d   = '0;
                    cnt_d   = '0;
                    rcnt_d  = '0;
                end
            end
            RST: begin
                rcnt_d  = rcnt_q + 32'd1;
                state_d = abort ? IDLE : (rcnt_q == 32'(RST_CYCLES - 1)) ? SETTLE : RST;
            end
            SETTLE: state_d = abort ? IDLE : (cyc_q != '0) ? RUN : DONE;
            // The vector applied this cycle is counted even if abort ends the run here.
            RUN: begin
                vec_d   = gen_vec;
                lcg_d   = gen_end;
                cnt_d   = cnt_q + 32'd1;
                sig_d   = {sig_q[30:0], sig_q[31]} ^ fold;
                state_d = abort ? IDLE : (cnt_d == cyc_q) ? DONE : RUN;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            lcg_q       <= '0;
            cyc_q       <= '0;
            sig_q       <= '0;
            cnt_q       <= '0;
            rcnt_q      <= '0;
            vec_q       <= '0;
            dut_rst_n_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            lcg_q       <= lcg_d;
            cyc_q       <= cyc_d;
            sig_q       <= sig_d;
            cnt_q       <= cnt_d;
            rcnt_q      <= rcnt_d;
            vec_q       <= vec_d;
            dut_rst_n_q <= (state_d != RST);
        end
    end

    assign dut_rst_n = dut_rst_n_q;
    assign in_flat   = vec_q;
    assign busy      = (state_q != IDLE);
    assign done      = (state_q == DONE);
    assign signature = sig_q;
    assign vec_cnt   = cnt_q;
endmodule

// File: tb/tb_fuzz_stim_ctrl.sv
// tb_fuzz_stim_ctrl: scoreboard bench; expected run results are queued at start and retired at done/abort.
module tb_fuzz_stim_ctrl;
    localparam int IN_W  = 136;
    localparam int OUT_W = 159;
    localparam int R     = 2;
    localparam int IW    = (IN_W + 31) / 32;
    localparam int OWW   = (OUT_W + 31) / 32;

    logic             clk = 0, rst_n = 0, start = 0, abort = 0, ones = 0;
    logic [31:0]      seed = 0, cycles = 0;
    logic             dut_rst_n, busy, done;
    logic [IN_W-1:0]  in_flat;
    logic [OUT_W-1:0] out_flat;
    logic [31:0]      signature, vec_cnt;
    int               n_vec = 0, n_bad = 0;

    typedef struct {logic [31:0] sig; logic [31:0] cnt; int lat;} exp_t;
    exp_t            sb[$];
    logic [IN_W-1:0] vs[$];

    fuzz_stim_ctrl #(.IN_W(IN_W), .OUT_W(OUT_W), .RST_CYCLES(R)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .seed(seed), .cycles(cycles),
        .dut_rst_n(dut_rst_n), .in_flat(in_flat), .out_flat(out_flat), .busy(busy), .done(done),
        .signature(signature), .vec_cnt(vec_cnt)
    );

    always #5 clk = ~clk;

    // Stand-in DUT: response is a fixed scramble of the stimulus, or all-ones.
    function automatic logic [OUT_W-1:0] resp(input logic [IN_W-1:0] v);
        return ones ? '1 : {v[22:0], ~v};
    endfunction

    assign out_flat = resp(in_flat);

    function automatic logic [31:0] fold(input logic [OUT_W-1:0] r);
        logic [OWW*32-1:0] p;
        logic [31:0]       f;
        p = '0;
        p[OUT_W-1:0] = r;
        f = '0;
        for (int k = 0; k < OWW; k++) f ^= p[32*k +: 32];
        return f;
    endfunction

    task automatic gen(input logic [31:0] s, output logic [IN_W-1:0] v, output logic [31:0] so);
        logic [IW*32-1:0] w;
        so = s;
        for (int k = 0; k < IW; k++) begin
            so = so * 32'h41C64E6D + 32'h3039;
            w[32*k +: 32] = so;
        end
        v = w[IN_W-1:0];
    endtask

    task automatic check(input string tag, input logic [159:0] got, input logic [159:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // ab: cycle index (0 = RST entry) at which abort is raised, 0 for none; inj: stray starts in RUN and DONE.
    task automatic run(input logic [31:0] s, input logic [31:0] n, input int ab, input bit inj);
        exp_t            e;
        logic [IN_W-1:0] v;
        logic [31:0]     st, sig;
        int              t, low, m, idx;
        m = (ab != 0) ? ab - R : int'(n);
        vs.delete();
        gen(s, v, st);
        vs.push_back(v);
        sig = '0;
        for (int j = 0; j < int'(n); j++) begin
            if (j < m) sig = {sig[30:0], sig[31]} ^ fold(resp(v));
            gen(st, v, st);
            vs.push_back(v);
        end
        e.sig = sig;
        e.cnt = m;
        e.lat = R + 1 + int'(n);
        sb.push_back(e);
        @(negedge clk);
        start = 1; seed = s; cycles = n;
        @(negedge clk);
        start = 0; seed = $urandom;
        t = 0; low = 0;
        while (!done && t < 1000) begin
            if (ab != 0 && t == ab + 1) break;
            idx = (t > R + 1) ? t - R - 1 : 0;
            if (idx < vs.size()) check("in_flat", in_flat, vs[idx]);
            if (s == 0 && t == 0) begin
                check("first_w0", in_flat[31:0], 32'h00003039);
                check("first_w1", in_flat[63:32], 32'hD3DC167E);
            end
            if (!dut_rst_n) low++;
            start = inj && t == R + 2;
            abort = (ab != 0) && t == ab;
            @(negedge clk);
            t++;
        end
        start = 0; abort = 0;
        e = sb.pop_front();
        check("rst_low", low, R);
        check("vec_cnt", vec_cnt, e.cnt);
        check("signature", signature, e.sig);
        if (ab != 0) begin
            check("abort_busy", busy, 0);
            check("abort_rst_n", dut_rst_n, 1);
            low = 0;
            repeat (4) begin
                low += done;
                @(negedge clk);
            end
            check("abort_no_done", low, 0);
            check("abort_frozen", vec_cnt, e.cnt);
        end else begin
            check("latency", t, e.lat);
            check("done", done, 1);
            check("done_rst_n", dut_rst_n, 1);
            start = inj;
            @(negedge clk);
            start = 0;
            check("done_pulse", done, 0);
            check("idle_busy", busy, 0);
            @(negedge clk);
            check("stray_start", busy, 0);
        end
    endtask

    initial begin
        #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_dut_rst_n", dut_rst_n, 0);
        check("rst_in_flat", in_flat, 0);
        check("rst_sig", signature, 0);
        check("rst_cnt", vec_cnt, 0);
        repeat (2) @(negedge clk);
        rst_n = 1;
        @(negedge clk);
        check("idle_rst_n", dut_rst_n, 1);
        check("idle_busy0", busy, 0);
        run(32'd0, 32'd3, 0, 0);
        run(32'h0BAD_F00D, 32'd0, 0, 0);
        ones = 1;
        run(32'h1234_5678, 32'd1, 0, 0);
        ones = 0;
        run(32'hCAFE_BABE, 32'd10, R + 2, 0);
        run(32'd777, 32'd5, 0, 1);
        run(32'd777, 32'd5, 0, 0);
        @(negedge clk);
        start = 1; seed = 32'd99; cycles = 32'd20;
        @(negedge clk);
        start = 0;
        repeat (6) @(negedge clk);
        #2 rst_n = 0;
        #1;
        check("mid_busy", busy, 0);
        check("mid_done", done, 0);
        check("mid_dut_rst_n", dut_rst_n, 0);
        check("mid_in_flat", in_flat, 0);
        check("mid_sig", signature, 0);
        check("mid_cnt", vec_cnt, 0);
        @(negedge clk);
        rst_n = 1;
        @(negedge clk);
        check("post_rst_n", dut_rst_n, 1);
        check("post_busy", busy, 0);
        run(32'd42, 32'd4, 0, 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
